// File: rtl/home_command_transmitter_pkg.sv
// Shared definitions for the home command link: field widths, transmitter
// FSM encoding and the command type codes the receiver's decoder expects.

`ifndef COMMAND_CONTROL_TYPE_WIDTH
`define COMMAND_CONTROL_TYPE_WIDTH 2
`endif

`ifndef COMMAND_CONTROL_DATA_WIDTH
`define COMMAND_CONTROL_DATA_WIDTH 8
`endif

package home_command_transmitter_pkg;

    // Transmitter sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } tx_state_t;

    // Command type codes, kept identical to the receiver's decoder
    localparam logic [`COMMAND_CONTROL_TYPE_WIDTH-1:0] CMD_ECO          = 'd0;
    localparam logic [`COMMAND_CONTROL_TYPE_WIDTH-1:0] CMD_AC_MODE      = 'd1;
    localparam logic [`COMMAND_CONTROL_TYPE_WIDTH-1:0] CMD_PERSON_COUNT = 'd2;
    localparam logic [`COMMAND_CONTROL_TYPE_WIDTH-1:0] CMD_SECURITY     = 'd3;

endpackage

// File: rtl/home_command_transmitter_command_fifo.sv
// Small synchronous FIFO holding pending command requests. Besides the head
// entry it exposes the entry behind the head, so the sequencer can load the
// next command into its output registers in the same cycle it pops.

module home_command_transmitter_command_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [WIDTH-1:0]         head_next,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_inc;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    // Full/empty come from the registered count only; a pop in the same cycle
    // never opens room for a push.
    assign full       = (count_reg == CNT_W'(DEPTH));
    assign empty      = (count_reg == '0);
    assign count      = count_reg;
    assign do_push    = push & ~full & ~flush;
    assign do_pop     = pop & ~empty & ~flush;
    assign rd_ptr_inc = rd_ptr_reg + PTR_W'(1);

    // Storage is tiny, so reads are asynchronous from the entry array
    assign head      = mem[rd_ptr_reg];
    assign head_next = mem[rd_ptr_inc];

    // Write the incoming request into the tail slot
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/home_command_transmitter.sv
// Remote-control side of the home command interface. Buffers requests and
// replays each one REPEAT_COUNT times as single-cycle strobes separated by at
// least GAP_CYCLES idle cycles.

module home_command_transmitter
    import home_command_transmitter_pkg::*;
#(
    parameter int TYPE_W       = `COMMAND_CONTROL_TYPE_WIDTH,
    parameter int DATA_W       = `COMMAND_CONTROL_DATA_WIDTH,
    parameter int FIFO_DEPTH   = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int REPEAT_COUNT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    input  logic [TYPE_W-1:0] req_type_i,
    input  logic [DATA_W-1:0] req_data_i,
    output logic              req_ready_o,
    input  logic              flush_i,
    output logic              command_valid_o,
    output logic [TYPE_W-1:0] command_type_o,
    output logic [DATA_W-1:0] command_data_o,
    output logic              busy_o,
    output logic              overflow_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int REP_W = $clog2(REPEAT_COUNT + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int ENT_W = TYPE_W + DATA_W;
    localparam logic [REP_W-1:0] REP_LOAD = REP_W'(REPEAT_COUNT - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    tx_state_t         state_reg;
    tx_state_t         state_next;
    logic [REP_W-1:0]  repeat_cnt_reg;
    logic [GAP_W-1:0]  gap_cnt_reg;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [ENT_W-1:0]  fifo_head;
    logic [ENT_W-1:0]  fifo_head_next;

    logic              valid_next;
    logic [TYPE_W-1:0] type_next;
    logic [DATA_W-1:0] data_next;

    assign req_ready_o = ~fifo_full;
    assign fifo_push   = req_valid_i & ~fifo_full & ~flush_i;
    assign busy_o      = (fifo_count != '0) | (state_reg != IDLE);

    home_command_transmitter_command_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_command_fifo (
        .clk       (clk_i),
        .srst      (rst_i),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .flush     (flush_i),
        .din       ({req_type_i, req_data_i}),
        .head      (fifo_head),
        .head_next (fifo_head_next),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; the head is popped in the last gap cycle of its final
    // repetition. An entry pushed in that same cycle is not counted, so it is
    // picked up through IDLE rather than skipped.
    always_comb begin
        state_next = state_reg;
        fifo_pop   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                state_next = GAP;
            end
            GAP: begin
                if (gap_cnt_reg == '0) begin
                    if (repeat_cnt_reg != '0) begin
                        state_next = SEND;
                    end else begin
                        fifo_pop   = 1'b1;
                        state_next = (fifo_count > CNT_W'(1)) ? SEND : IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (flush_i) begin
            state_next = IDLE;
            fifo_pop   = 1'b0;
        end
    end

    // Repeat and gap counters
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            repeat_cnt_reg <= '0;
            gap_cnt_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (state_next == SEND) begin
                        repeat_cnt_reg <= REP_LOAD;
                    end
                end
                SEND: begin
                    gap_cnt_reg <= GAP_LOAD;
                end
                GAP: begin
                    if (gap_cnt_reg != '0) begin
                        gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
                    end else if (repeat_cnt_reg != '0) begin
                        repeat_cnt_reg <= repeat_cnt_reg - REP_W'(1);
                    end else begin
                        repeat_cnt_reg <= REP_LOAD;
                    end
                end
                default: begin
                    repeat_cnt_reg <= '0;
                end
            endcase
        end
    end

    // Output values for the next cycle; when popping into SEND the entry
    // behind the head becomes the command being sent.
    always_comb begin
        valid_next = (state_next == SEND);
        type_next  = command_type_o;
        data_next  = command_data_o;
        case (state_next)
            IDLE: begin
                type_next = '0;
                data_next = '0;
            end
            SEND: begin
                {type_next, data_next} = fifo_pop ? fifo_head_next : fifo_head;
            end
            default: begin
                type_next = command_type_o;
                data_next = command_data_o;
            end
        endcase
    end

    // Registered command outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            command_valid_o <= 1'b0;
            command_type_o  <= '0;
            command_data_o  <= '0;
        end else begin
            command_valid_o <= valid_next;
            command_type_o  <= type_next;
            command_data_o  <= data_next;
        end
    end

    // Sticky overflow flag for requests offered while the FIFO was full
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            overflow_o <= 1'b0;
        end else if (req_valid_i && !req_ready_o) begin
            overflow_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_home_command_transmitter.sv
// Bench for home_command_transmitter. Two instances share one stimulus stream:
// instance 0 uses the defaults (gap 2, one transmission), instance 1 uses
// gap 1 with three transmissions. Each is checked every cycle against a
// timeline model: a list of accepted requests plus the cycle at which the
// head's first strobe occurs.

module tb_home_command_transmitter;
    import home_command_transmitter_pkg::*;

    localparam int TW    = `COMMAND_CONTROL_TYPE_WIDTH;
    localparam int DW    = `COMMAND_CONTROL_DATA_WIDTH;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic [TW-1:0] req_type;
    logic [DW-1:0] req_data;
    logic          flush;

    logic          ready0, valid0, busy0, ovf0;
    logic [TW-1:0] type0;
    logic [DW-1:0] data0;
    logic          ready1, valid1, busy1, ovf1;
    logic [TW-1:0] type1;
    logic [DW-1:0] data1;

    int n_checks;
    int n_fails;
    int cyc;

    // Model state per instance
    logic [TW+DW-1:0] mq [2][8];
    int               mq_n [2];
    int               tx [2];
    logic             ovf_m [2];

    home_command_transmitter #(
        .FIFO_DEPTH   (DEPTH),
        .GAP_CYCLES   (2),
        .REPEAT_COUNT (1)
    ) dut0 (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (req_valid),
        .req_type_i      (req_type),
        .req_data_i      (req_data),
        .req_ready_o     (ready0),
        .flush_i         (flush),
        .command_valid_o (valid0),
        .command_type_o  (type0),
        .command_data_o  (data0),
        .busy_o          (busy0),
        .overflow_o      (ovf0)
    );

    home_command_transmitter #(
        .FIFO_DEPTH   (DEPTH),
        .GAP_CYCLES   (1),
        .REPEAT_COUNT (3)
    ) dut1 (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (req_valid),
        .req_type_i      (req_type),
        .req_data_i      (req_data),
        .req_ready_o     (ready1),
        .flush_i         (flush),
        .command_valid_o (valid1),
        .command_type_o  (type1),
        .command_data_o  (data1),
        .busy_o          (busy1),
        .overflow_o      (ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int gap_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic int rep_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Advance the model across one clock edge using the inputs held at that edge
    task automatic model_edge(input int k);
        int  g;
        int  r;
        bit  rdy;
        g = gap_of(k);
        r = rep_of(k);
        if (rst || flush) begin
            mq_n[k]  = 0;
            tx[k]    = -1;
            ovf_m[k] = 1'b0;
        end else begin
            rdy = (mq_n[k] < DEPTH);
            if (req_valid && !rdy) ovf_m[k] = 1'b1;
            if (tx[k] >= 0 && cyc == tx[k] + r * (g + 1) - 1) begin
                for (int i = 0; i < 7; i++) mq[k][i] = mq[k][i+1];
                mq_n[k]--;
                tx[k] = (mq_n[k] > 0) ? cyc + 1 : -1;
            end else if (tx[k] < 0 && mq_n[k] > 0) begin
                tx[k] = cyc + 1;
            end
            if (req_valid && rdy) begin
                mq[k][mq_n[k]] = {req_type, req_data};
                mq_n[k]++;
            end
        end
    endtask

    task automatic check_all();
        int               d;
        int               g;
        int               r;
        logic             ev;
        logic [TW+DW-1:0] ent;
        logic             o_v, o_r, o_b, o_o;
        logic [TW-1:0]    o_t;
        logic [DW-1:0]    o_d;
        for (int k = 0; k < 2; k++) begin
            g   = gap_of(k);
            r   = rep_of(k);
            ev  = 1'b0;
            ent = '0;
            if (tx[k] >= 0) begin
                d   = cyc - tx[k];
                ev  = (d % (g + 1) == 0) && (d / (g + 1) < r);
                ent = mq[k][0];
            end
            o_v = (k == 0) ? valid0 : valid1;
            o_t = (k == 0) ? type0  : type1;
            o_d = (k == 0) ? data0  : data1;
            o_r = (k == 0) ? ready0 : ready1;
            o_b = (k == 0) ? busy0  : busy1;
            o_o = (k == 0) ? ovf0   : ovf1;
            check($sformatf("valid%0d", k), 32'(o_v), 32'(ev));
            check($sformatf("type%0d", k), 32'(o_t), 32'(ent[TW+DW-1:DW]));
            check($sformatf("data%0d", k), 32'(o_d), 32'(ent[DW-1:0]));
            check($sformatf("ready%0d", k), 32'(o_r), 32'(mq_n[k] < DEPTH));
            check($sformatf("busy%0d", k), 32'(o_b), 32'((mq_n[k] > 0) || (tx[k] >= 0)));
            check($sformatf("overflow%0d", k), 32'(o_o), 32'(ovf_m[k]));
        end
        if (valid0 === 1'b1) $display("strobe inst0 cyc=%0d type=%0h data=%0h", cyc, type0, data0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        cyc++;
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic [TW-1:0] t, input logic [DW-1:0] d,
                         input logic fl, input logic rs);
        req_valid = v;
        req_type  = t;
        req_data  = d;
        flush     = fl;
        rst       = rs;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        cyc       = 0;
        req_valid = 1'b0;
        req_type  = '0;
        req_data  = '0;
        flush     = 1'b0;
        rst       = 1'b1;
        for (int k = 0; k < 2; k++) begin
            mq_n[k]  = 0;
            tx[k]    = -1;
            ovf_m[k] = 1'b0;
        end

        // Reset and its default outputs
        for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, 1'b0, 1'b1);
        check("reset_ready", 32'(ready0), 32'd1);
        check("reset_valid", 32'(valid0), 32'd0);
        check("reset_busy", 32'(busy1), 32'd0);
        check("reset_overflow", 32'(ovf1), 32'd0);
        idle(6);

        // Single request, type 3 data 0x15
        drive(1'b1, CMD_SECURITY, 8'h15, 1'b0, 1'b0);
        idle(1);
        check("first_strobe_latency", 32'(valid0), 32'd1);
        check("first_strobe_data", 32'(data0), 32'h15);
        idle(10);

        // Back-to-back requests with all four type codes
        drive(1'b1, CMD_ECO,          DW'($urandom), 1'b0, 1'b0);
        drive(1'b1, CMD_AC_MODE,      DW'($urandom), 1'b0, 1'b0);
        drive(1'b1, CMD_PERSON_COUNT, DW'($urandom), 1'b0, 1'b0);
        drive(1'b1, CMD_SECURITY,     DW'($urandom), 1'b0, 1'b0);
        idle(30);

        // Overflow: six offers while the first entry is being sent
        drive(1'b1, TW'($urandom), DW'($urandom), 1'b0, 1'b0);
        idle(1);
        for (int i = 0; i < 6; i++) drive(1'b1, TW'($urandom), DW'($urandom), 1'b0, 1'b0);
        idle(50);
        check("overflow_sticky", 32'(ovf0), 32'd1);
        drive(1'b0, '0, '0, 1'b1, 1'b0);

        // Repeated request 0xA5
        drive(1'b1, CMD_AC_MODE, 8'hA5, 1'b0, 1'b0);
        idle(10);

        // Flush with entries queued (mid-GAP for inst0, during SEND for inst1)
        for (int i = 0; i < 4; i++) drive(1'b1, TW'($urandom), DW'($urandom), 1'b0, 1'b0);
        drive(1'b1, TW'($urandom), DW'($urandom), 1'b1, 1'b0);
        check("flush_busy", 32'(busy0), 32'd0);
        drive(1'b1, TW'($urandom), DW'($urandom), 1'b0, 1'b0);
        idle(12);

        // Sequential pushes to wrap the pointers
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, TW'($urandom), DW'($urandom), 1'b0, 1'b0);
            idle(11);
        end

        // Reset during SEND
        drive(1'b1, TW'($urandom), DW'($urandom), 1'b0, 1'b0);
        idle(1);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        check("rst_send_valid", 32'(valid0), 32'd0);
        check("rst_send_ready", 32'(ready1), 32'd1);
        idle(3);

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 9) < 4), TW'($urandom), DW'($urandom),
                  ($urandom_range(0, 49) == 0), ($urandom_range(0, 99) == 0));
        end
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
